// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN-ordered request latch and travel/door sequencer for a 3-floor car.
// Optional feature macro: ELEVATOR_DOOR_HOLD_EN (adds door_hold input).
`default_nettype none

module elevator_scheduler #(
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] call,
`ifdef ELEVATOR_DOOR_HOLD_EN
    input  logic       door_hold,
`endif
    output logic [2:0] floor,
    output logic       door,
    output logic       moving,
    output logic       dir_up,
    output logic [2:0] pending
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);

    localparam logic [TW-1:0] c_travel_last = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] c_door_last   = TW'(DOOR_CYCLES - 1);
    localparam logic [TW-1:0] c_zero        = '0;
    localparam logic [TW-1:0] c_one         = TW'(1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE      = 2'd1,
        ST_DOOR_OPEN = 2'd2
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_floor;
    logic            r_door;
    logic            r_moving;
    logic            r_dir_up;
    logic [2:0]      r_pending;

    logic            w_at_rest;
    logic            w_cur_call;
    logic [2:0]      w_latch;
    logic [2:0]      w_above;
    logic [2:0]      w_below;
    logic            w_dir_new;
    logic [2:0]      w_next_floor;
    logic            w_hold;

`ifdef ELEVATOR_DOOR_HOLD_EN
    assign w_hold = door_hold;
`else
    assign w_hold = 1'b0;
`endif

    // A call for the floor the car is standing at reopens the door rather than latching.
    assign w_at_rest  = (r_state == ST_IDLE) || (r_state == ST_DOOR_OPEN);
    assign w_cur_call = |(call & r_floor);
    assign w_latch    = r_pending | (w_at_rest ? (call & ~r_floor) : call);

    assign w_above   = {r_floor[1] | r_floor[0], r_floor[0], 1'b0};
    assign w_below   = {1'b0, r_floor[2], r_floor[2] | r_floor[1]};
    assign w_dir_new = r_dir_up ? (|(r_pending & w_above)) : ~(|(r_pending & w_below));

    assign w_next_floor = r_dir_up ? (r_floor[2] ? r_floor : {r_floor[1:0], 1'b0})
                                   : (r_floor[0] ? r_floor : {1'b0, r_floor[2:1]});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_timer   <= c_zero;
            r_floor   <= 3'b001;
            r_door    <= 1'b0;
            r_moving  <= 1'b0;
            r_dir_up  <= 1'b1;
            r_pending <= 3'b000;
        end else begin
            r_pending <= w_latch;
            case (r_state)
                ST_IDLE: begin
                    if (w_cur_call) begin
                        r_door  <= 1'b1;
                        r_timer <= c_zero;
                        r_state <= ST_DOOR_OPEN;
                    end else if (|r_pending) begin
                        r_dir_up <= w_dir_new;
                        r_moving <= 1'b1;
                        r_timer  <= c_zero;
                        r_state  <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    if (r_timer == c_travel_last) begin
                        r_floor <= w_next_floor;
                        r_timer <= c_zero;
                        if (|(w_latch & w_next_floor)) begin
                            r_pending <= w_latch & ~w_next_floor;
                            r_moving  <= 1'b0;
                            r_door    <= 1'b1;
                            r_state   <= ST_DOOR_OPEN;
                        end
                    end else begin
                        r_timer <= r_timer + c_one;
                    end
                end
                ST_DOOR_OPEN: begin
                    if (w_cur_call) begin
                        r_timer <= c_zero;
                    end else if (w_hold) begin
                        r_timer <= r_timer;
                    end else if (r_timer == c_door_last) begin
                        r_door  <= 1'b0;
                        r_timer <= c_zero;
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + c_one;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign floor   = r_floor;
    assign door    = r_door;
    assign moving  = r_moving;
    assign dir_up  = r_dir_up;
    assign pending = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
// Directed self-checking bench for elevator_scheduler (TRAVEL_CYCLES=4, DOOR_CYCLES=3).
`default_nettype none

module tb_elevator_scheduler;

    logic       clk;
    logic       rst_n;
    logic [2:0] call;
    logic       door_hold;
    logic [2:0] floor;
    logic       door;
    logic       moving;
    logic       dir_up;
    logic [2:0] pending;

    int checks;
    int errors;

    elevator_scheduler #(
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES  (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .call     (call),
`ifdef ELEVATOR_DOOR_HOLD_EN
        .door_hold(door_hold),
`endif
        .floor    (floor),
        .door     (door),
        .moving   (moving),
        .dir_up   (dir_up),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive call for one edge, then check the always-true invariants 1 time unit later.
    task automatic step(input logic [2:0] c);
        call = c;
        @(posedge clk);
        #1;
        call = 3'b000;
        chk("inv_move_door", {2'b00, moving & door}, 3'b000);
        chk("inv_onehot", {2'b00, $onehot(floor)}, 3'b001);
    endtask

    task automatic chk_all(input string tag, input logic [2:0] f, input logic d,
                           input logic m, input logic u, input logic [2:0] p);
        chk({tag, "_floor"}, floor, f);
        chk({tag, "_door"}, {2'b00, door}, {2'b00, d});
        chk({tag, "_moving"}, {2'b00, moving}, {2'b00, m});
        chk({tag, "_dir_up"}, {2'b00, dir_up}, {2'b00, u});
        chk({tag, "_pending"}, pending, p);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        call      = 3'b000;
        door_hold = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 3'b001, 1'b0, 1'b0, 1'b1, 3'b000);
        rst_n = 1'b1;
        step(3'b000);
        chk_all("idle", 3'b001, 1'b0, 1'b0, 1'b1, 3'b000);

        // Single call to floor3 from floor1.
        step(3'b100);
        chk_all("s_E0", 3'b001, 1'b0, 1'b0, 1'b1, 3'b100);
        step(3'b000);
        chk_all("s_E1", 3'b001, 1'b0, 1'b1, 1'b1, 3'b100);
        repeat (3) begin
            step(3'b000);
            chk_all("s_E2_4", 3'b001, 1'b0, 1'b1, 1'b1, 3'b100);
        end
        step(3'b000);
        chk_all("s_E5", 3'b010, 1'b0, 1'b1, 1'b1, 3'b100);
        repeat (3) begin
            step(3'b000);
            chk_all("s_E6_8", 3'b010, 1'b0, 1'b1, 1'b1, 3'b100);
        end
        step(3'b000);
        chk_all("s_E9", 3'b100, 1'b1, 1'b0, 1'b1, 3'b000);
        repeat (2) begin
            step(3'b000);
            chk_all("s_E10_11", 3'b100, 1'b1, 1'b0, 1'b1, 3'b000);
        end
        step(3'b000);
        chk_all("s_E12", 3'b100, 1'b0, 1'b0, 1'b1, 3'b000);

        // Current-floor call opens the door; a repeat restarts the door period.
        step(3'b100);
        chk_all("cf_open", 3'b100, 1'b1, 1'b0, 1'b1, 3'b000);
        step(3'b000);
        step(3'b100);
        chk_all("cf_reopen", 3'b100, 1'b1, 1'b0, 1'b1, 3'b000);
        repeat (2) begin
            step(3'b000);
            chk_all("cf_held", 3'b100, 1'b1, 1'b0, 1'b1, 3'b000);
        end
        step(3'b000);
        chk_all("cf_close", 3'b100, 1'b0, 1'b0, 1'b1, 3'b000);

`ifdef ELEVATOR_DOOR_HOLD_EN
        step(3'b100);
        chk_all("dh_open", 3'b100, 1'b1, 1'b0, 1'b1, 3'b000);
        door_hold = 1'b1;
        repeat (5) begin
            step(3'b000);
            chk_all("dh_hold", 3'b100, 1'b1, 1'b0, 1'b1, 3'b000);
        end
        door_hold = 1'b0;
        repeat (2) begin
            step(3'b000);
            chk_all("dh_resume", 3'b100, 1'b1, 1'b0, 1'b1, 3'b000);
        end
        step(3'b000);
        chk_all("dh_close", 3'b100, 1'b0, 1'b0, 1'b1, 3'b000);
`endif

        // SCAN: call floor1 while passing floor2 on the way up to floor3.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step(3'b100);
        chk_all("scan_E0", 3'b001, 1'b0, 1'b0, 1'b1, 3'b100);
        repeat (5) step(3'b000);
        chk_all("scan_E5", 3'b010, 1'b0, 1'b1, 1'b1, 3'b100);
        step(3'b001);
        chk_all("scan_E6", 3'b010, 1'b0, 1'b1, 1'b1, 3'b101);
        repeat (3) step(3'b000);
        chk_all("scan_E9", 3'b100, 1'b1, 1'b0, 1'b1, 3'b001);
        repeat (3) step(3'b000);
        chk_all("scan_E12", 3'b100, 1'b0, 1'b0, 1'b1, 3'b001);
        step(3'b000);
        chk_all("scan_E13", 3'b100, 1'b0, 1'b1, 1'b0, 3'b001);
        repeat (4) step(3'b000);
        chk_all("scan_E17", 3'b010, 1'b0, 1'b1, 1'b0, 3'b001);
        repeat (4) step(3'b000);
        chk_all("scan_E21", 3'b001, 1'b1, 1'b0, 1'b0, 3'b000);
        repeat (3) step(3'b000);
        chk_all("scan_E24", 3'b001, 1'b0, 1'b0, 1'b0, 3'b000);

        // Simultaneous calls for floors 2 and 3.
        step(3'b110);
        chk_all("sim_E0", 3'b001, 1'b0, 1'b0, 1'b0, 3'b110);
        step(3'b000);
        chk_all("sim_E1", 3'b001, 1'b0, 1'b1, 1'b1, 3'b110);
        repeat (4) step(3'b000);
        chk_all("sim_E5", 3'b010, 1'b1, 1'b0, 1'b1, 3'b100);
        repeat (2) step(3'b000);
        chk_all("sim_E7", 3'b010, 1'b1, 1'b0, 1'b1, 3'b100);
        step(3'b000);
        chk_all("sim_E8", 3'b010, 1'b0, 1'b0, 1'b1, 3'b100);
        step(3'b000);
        chk_all("sim_E9", 3'b010, 1'b0, 1'b1, 1'b1, 3'b100);
        repeat (4) step(3'b000);
        chk_all("sim_E13", 3'b100, 1'b1, 1'b0, 1'b1, 3'b000);
        repeat (3) step(3'b000);
        chk_all("sim_E16", 3'b100, 1'b0, 1'b0, 1'b1, 3'b000);

        // Asynchronous reset in the middle of a move.
        step(3'b001);
        chk_all("rm_E0", 3'b100, 1'b0, 1'b0, 1'b1, 3'b001);
        repeat (2) step(3'b000);
        chk_all("rm_E2", 3'b100, 1'b0, 1'b1, 1'b0, 3'b001);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("rm_async", 3'b001, 1'b0, 1'b0, 1'b1, 3'b000);
        @(posedge clk);
        #1;
        chk_all("rm_held", 3'b001, 1'b0, 1'b0, 1'b1, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Request scheduler and sequencer for the 3-floor elevator car.
- Latches hall/cab call buttons, chooses the next floor using SCAN ordering (keep direction while requests lie ahead) and sequences travel and door timing.
- Drives the one-hot floor, door and moving indications consumed by the display/movement layer.

Parameters:
- TRAVEL_CYCLES, 4, clock cycles to travel one floor (>=1)
- DOOR_CYCLES, 3, clock cycles the door stays open per stop (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- call  input  3  call buttons, bit0=floor1 .. bit2=floor3; level-sampled every cycle
- floor  output  3  one-hot current floor, bit0=floor1
- door  output  1  door open
- moving  output  1  car travelling
- dir_up  output  1  current/last travel direction, 1=up
- pending  output  3  latched outstanding requests

Behaviour:
- All outputs registered. Reset (async, rst_n=0): floor=001, door=0, moving=0, dir_up=1, pending=000, state IDLE, timer=0. Reset mid-move or mid-door aborts immediately to these values.
- Timer width = clog2(max(TRAVEL_CYCLES,DOOR_CYCLES)+1).
- Request latch, every edge:
  - pending[i] set when call[i]=1.
  - Exception: a call for the current floor while in IDLE or DOOR_OPEN is not latched; it opens or re-opens the door instead.
  - While MOVE, a call for the floor just left is latched normally.
  - Multiple simultaneous call bits are all accepted.
- States: IDLE, MOVE, DOOR_OPEN.
- IDLE:
  - Call for the current floor: next edge door=1, timer=0, go to DOOR_OPEN.
  - Else, pending != 0: pick direction. Keep dir_up if any pending bit lies ahead in that direction, else reverse. Next edge moving=1, timer=0, go to MOVE.
  - Else stay in IDLE.
- MOVE:
  - timer increments each cycle.
  - When timer reaches TRAVEL_CYCLES-1, on that edge floor shifts one position in dir_up direction and timer=0.
  - If the new floor is pending, on the same edge: clear that pending bit, moving=0, door=1, go to DOOR_OPEN.
  - Otherwise stay in MOVE (pass through).
  - The car never shifts beyond floor 001 or 100. Direction is re-evaluated only in IDLE, so a request behind the car waits until the current sweep completes.
- DOOR_OPEN:
  - door=1 for exactly DOOR_CYCLES cycles, then door=0 and go to IDLE on that edge.
  - A current-floor call during DOOR_OPEN restarts timer to 0.
- Latency, call sampled at edge E0 from IDLE, car one floor away: pending set at E0, moving=1 at E1, floor change + door=1 at E1+TRAVEL_CYCLES, door=0 at E1+TRAVEL_CYCLES+DOOR_CYCLES.
- Invariants:
  - moving and door are never both 1.
  - floor is always exactly one-hot.
  - pending never contains the current floor while in IDLE or DOOR_OPEN.

Optional Feature:
- Macro ELEVATOR_DOOR_HOLD_EN.
- Defined: extra input port door_hold (1 bit). While door_hold=1 in DOOR_OPEN, the timer is held and the door stays open. Closing resumes counting from the held value. door_hold has no effect in other states.
- Undefined: port absent; door timing is purely DOOR_CYCLES.

Test Plan:
- Reset: assert rst_n=0 mid-MOVE at an arbitrary time -> floor=001, door=0, moving=0, dir_up=1, pending=000 immediately, without waiting for clk.
- Single call, defaults: from floor1 idle, pulse call=100 for one cycle sampled at E0 -> pending=100 at E0, moving=1 at E1, floor=010 at E5 (pass-through, door stays 0), floor=100 with door=1, moving=0, pending=000 at E9, door=0 at E12.
- Current-floor call: idle at floor1, call=001 -> door=1 next edge, pending stays 000. Repeat call=001 while door open -> door-open period restarts, door=0 exactly 3 cycles after the last call.
- SCAN order: car moving up from floor1 toward floor3; while at floor2 in pass-through, call=001 -> car continues to floor3 and stops, then reverses (dir_up=0) and serves floor1. Check pending transitions 101 -> 001 -> 000.
- Simultaneous calls: idle at floor1, call=110 in one cycle -> stops at floor2 then floor3, each with a 3-cycle door period. moving and door never both 1.
- With ELEVATOR_DOOR_HOLD_EN: door_hold=1 for 5 cycles during DOOR_OPEN -> door stays 1 throughout, closes DOOR_CYCLES minus elapsed cycles after release.
